instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the vector ASIP; sits directly upstream of control_unit.
- Walks a PC over a synchronous-read instruction memory and drives a 32-bit IF/ID register that feeds the control unit's instr input.
- Supports start/done run control, pipeline stall and abort.
- Emits the NOP encoding whenever no valid instruction is present.

Parameters:
ADDR_W, 8, instruction memory address width
PROG_LEN, 8, number of instructions per run; legal range 1..2**ADDR_W
NOP_INSTR, 32'h50000000, word driven on instr when instr_valid=0

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled in IDLE only
stall  in  1  freeze PC, memory read and IF/ID register
abort  in  1  synchronous cancel of the current run
imem_en  out  1  memory read enable; memory output holds when 0
imem_addr  out  ADDR_W  read address (registered PC)
imem_data  in  32  memory read data, valid 1 cycle after an enabled read
instr  out  32  IF/ID register to control_unit
instr_valid  out  1  instr holds a fetched word
instr_pc  out  ADDR_W  address of the word in instr
busy  out  1  state is RUN or DRAIN
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (async, rst=1), all outputs:
  - state=IDLE, pc=0, fetch_v=0
  - instr=NOP_INSTR, instr_valid=0, instr_pc=0
  - imem_en=0, imem_addr=0, busy=0, done=0
- imem_addr=pc at all times.
- imem_en=1 only in RUN with stall=0.
- fetch_v is an internal flag: imem_data currently holds a word read for this run. fetch_pc is its address.
- IDLE:
  - start=1 -> RUN, pc=0; all other outputs keep reset values.
  - abort in IDLE has no effect.
- RUN, stall=0:
  - Read issued at pc; at the edge, pc<=pc+1, fetch_v<=1, fetch_pc<=pc.
  - IF/ID loads: instr<=fetch_v ? imem_data : NOP_INSTR, instr_valid<=fetch_v, instr_pc<=fetch_pc.
  - If pc==PROG_LEN-1 (last read issued) -> DRAIN; pc does not wrap and stays at PROG_LEN-1.
- DRAIN, stall=0:
  - No new read; fetch_v<=0; IF/ID loads as in RUN.
  - When fetch_v=0 and instr_valid=1, the last word is being consumed: IF/ID loads NOP, -> DONE.
- DONE: done=1 for exactly this cycle; -> IDLE unconditionally; start is ignored this cycle.
- stall=1 (RUN or DRAIN):
  - pc, fetch_v, fetch_pc, IF/ID and state all hold.
  - imem_en=0, so memory output holds; no word is lost or duplicated.
- Latency:
  - start sampled at edge E0.
  - addr 0 read during E0..E1.
  - instr=mem[0], instr_valid=1 after E2.
  - With no stalls, one new word per cycle.
  - done after edge E(PROG_LEN+2).
- abort=1 in RUN/DRAIN (sync, overrides stall and start):
  - -> IDLE, pc=0, fetch_v=0, instr=NOP_INSTR, instr_valid=0; done not pulsed.
- rst mid-run: immediate return to reset values regardless of clk; no done.
- PROG_LEN=1: RUN lasts one cycle, then DRAIN.
- Simultaneous stall and state exit: stall wins; no transition out of RUN/DRAIN while stall=1, except abort.

Test Plan:
- Straight run: PROG_LEN=7, memory loaded with 0x20000190, 0x00000000, 0x10000000, 0x4C000000, 0x50000000, 0x30000000, 0x68000000; start pulse at E0 -> instr shows those words on consecutive cycles from E2 with instr_pc 0..6; done=1 one cycle after E9; busy high E1..E9.
- Stall mid-stream: stall=1 for 3 cycles while instr=0x10000000 -> instr, instr_pc=2 and imem_addr hold, imem_en=0; after release, 0x4C000000 appears next with no skipped or repeated word.
- Abort: abort at the cycle after instr=0x4C000000 -> next edge instr=0x50000000, instr_valid=0, busy=0, no done pulse; a new start replays from address 0.
- Async reset: assert rst between clock edges while in RUN -> all outputs reach reset values before the next edge.
- Edge cases:
  - PROG_LEN=1 with mem[0]=0x68000000: one valid word, then done.
  - start held high through DONE: no restart until IDLE.
  - stall asserted in the DRAIN cycle where done would follow: done is delayed until stall drops.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: walks a PC over a synchronous-read instruction memory and feeds the
// IF/ID register of the control unit, with start/done run control, stall and abort.
module instr_fetch_unit #(
    parameter int          ADDR_W    = 8,
    parameter int          PROG_LEN  = 8,
    parameter logic [31:0] NOP_INSTR = 32'h5000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              abort,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fetch_v_q, fetch_v_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            fetch_v_q     <= 1'b0;
            fetch_pc_q    <= '0;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_v_q     <= fetch_v_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // Stall freezes everything; abort beats stall; memory data holds while imem_en=0,
    // so the word for fetch_pc is still on imem_data when the stall releases.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_v_d     = fetch_v_q;
        fetch_pc_d    = fetch_pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        instr_pc_d    = instr_pc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN, S_DRAIN: begin
                if (abort) begin
                    state_d       = S_IDLE;
                    pc_d          = '0;
                    fetch_v_d     = 1'b0;
                    fetch_pc_d    = '0;
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b0;
                    instr_pc_d    = '0;
                end else if (!stall) begin
                    instr_d       = fetch_v_q ? imem_data : NOP_INSTR;
                    instr_valid_d = fetch_v_q;
                    instr_pc_d    = fetch_pc_q;
                    if (state_q == S_RUN) begin
                        fetch_v_d  = 1'b1;
                        fetch_pc_d = pc_q;
                        if (pc_q == LAST_PC) begin
                            state_d = S_DRAIN;
                        end else begin
                            pc_d = pc_q + ADDR_W'(1);
                        end
                    end else begin
                        fetch_v_d = 1'b0;
                        if (!fetch_v_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                pc_d       = '0;
                fetch_pc_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_en     = (state_q == S_RUN) && !stall;
        imem_addr   = pc_q;
        instr       = instr_q;
        instr_valid = instr_valid_q;
        instr_pc    = instr_pc_q;
        busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
        done        = (state_q == S_DONE);
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed run/stall/abort/reset scenarios plus random
// stall/abort runs, scored against an in-order list of expected {pc, word} pairs.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    localparam int          AW  = 8;
    localparam int          PL  = 7;
    localparam logic [31:0] NOP = 32'h5000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, stall = 1'b0, abort = 1'b0;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data = 32'h0;
    logic [31:0]   instr;
    logic          instr_valid;
    logic [AW-1:0] instr_pc;
    logic          busy, done;
    logic [1:0]    dbg_state;

    logic          p1_start = 1'b0;
    logic          p1_en;
    logic [AW-1:0] p1_addr;
    logic [31:0]   p1_data = 32'h0;
    logic [31:0]   p1_instr;
    logic          p1_valid;
    logic [AW-1:0] p1_pc;
    logic          p1_busy, p1_done;
    logic [1:0]    p1_state;

    logic [31:0]      mem [0:255];
    logic [AW+31:0]   exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(AW), .PROG_LEN(PL), .NOP_INSTR(NOP)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .abort(abort),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    instr_fetch_unit #(.ADDR_W(AW), .PROG_LEN(1), .NOP_INSTR(NOP)) u_dut_p1 (
        .clk(clk), .rst(rst), .start(p1_start), .stall(1'b0), .abort(1'b0),
        .imem_en(p1_en), .imem_addr(p1_addr), .imem_data(p1_data),
        .instr(p1_instr), .instr_valid(p1_valid), .instr_pc(p1_pc),
        .busy(p1_busy), .done(p1_done), .dbg_state(p1_state)
    );

    // Synchronous-read memories; output holds while the read enable is low.
    always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];
    always @(posedge clk) if (p1_en) p1_data <= (p1_addr == '0) ? 32'h6800_0000 : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a valid word counts as consumed on a cycle without stall or abort.
    always @(negedge clk) begin
        if (!rst) begin
            if (abort && busy) begin
                exp_q.delete();
            end else if (instr_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_word: got pc=%0h instr=%0h expected none", instr_pc, instr);
                end else begin
                    check("word", {instr_pc, instr}, exp_q.pop_front());
                end
            end
            if (!instr_valid) check("nop_when_invalid", instr, NOP);
            if (done) check("done_after_drain", exp_q.size(), 0);
        end
    end

    task automatic push_run();
        for (int i = 0; i < PL; i++) exp_q.push_back({AW'(i), mem[i]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch();
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
        end
        check({name, "_done_seen"}, done, 1'b1);
        tick();
    endtask

    task automatic wait_word(input logic [31:0] w);
        int cyc = 0;
        while (!(instr_valid && instr == w) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("wait_word_seen", instr, w);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, first, vcnt;
        logic [AW-1:0] held_addr;
        logic aborted, ab;
        mem[0] = 32'h2000_0190; mem[1] = 32'h0000_0000; mem[2] = 32'h1000_0000;
        mem[3] = 32'h4C00_0000; mem[4] = 32'h5000_0000; mem[5] = 32'h3000_0000;
        mem[6] = 32'h6800_0000;
        #12;
        check("rst_instr", instr, NOP);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_pc", instr_pc, 0);
        check("rst_en", imem_en, 1'b0);
        check("rst_addr", imem_addr, 0);
        check("rst_busy_done", {busy, done}, 2'b00);
        @(posedge clk); #3 rst = 1'b0;
        tick();

        // Straight run: first word after E2, done after E(PL+2).
        launch();
        cyc = 0; first = -1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
            if (instr_valid && first < 0) first = cyc;
            if (!done) check("busy_in_run", busy, 1'b1);
        end
        check("first_word_latency", first, 2);
        check("done_latency", cyc, PL + 2);
        check("done_busy_low", busy, 1'b0);
        tick();
        check("done_one_cycle", done, 1'b0);

        // Stall while 0x10000000 is presented.
        launch();
        wait_word(32'h1000_0000);
        held_addr = imem_addr;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_instr", instr, 32'h1000_0000);
            check("stall_pc", instr_pc, 2);
            check("stall_addr", imem_addr, held_addr);
            check("stall_en", imem_en, 1'b0);
            tick();
        end
        stall = 1'b0;
        wait_done("stall");

        // Abort the cycle after 0x4C000000, then replay from address 0.
        launch();
        wait_word(32'h4C00_0000);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_instr", instr, NOP);
        check("abort_valid", instr_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        for (int i = 0; i < 12; i++) begin
            check("abort_no_done", done, 1'b0);
            tick();
        end
        launch();
        wait_done("replay");

        // Asynchronous reset between edges mid-run.
        launch();
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_instr", instr, NOP);
        check("arst_valid", instr_valid, 1'b0);
        check("arst_pc", instr_pc, 0);
        check("arst_en_addr", {imem_en, imem_addr}, 0);
        check("arst_busy_done", {busy, done}, 2'b00);
        exp_q.delete();
        @(posedge clk); #3 rst = 1'b0;
        tick();

        // start held high through DONE: restart only from IDLE.
        push_run();
        start = 1'b1;
        tick();
        cyc = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("held_done_seen", done, 1'b1);
        tick();
        check("held_idle_after_done", {busy, done}, 2'b00);
        push_run();
        tick();
        check("held_restart", busy, 1'b1);
        start = 1'b0;
        wait_done("held");

        // Stall in the DRAIN cycle that precedes DONE.
        launch();
        cyc = 0;
        while (!(instr_valid && instr_pc == AW'(PL - 1)) && cyc < 100) begin
            tick();
            cyc++;
        end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("drain_stall_no_done", done, 1'b0);
            check("drain_stall_busy", busy, 1'b1);
            check("drain_stall_word", {instr_valid, instr}, {1'b1, mem[PL-1]});
        end
        stall = 1'b0;
        tick();
        check("drain_done_after_release", done, 1'b1);
        tick();

        // Random contents with random stalls and occasional aborts.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < PL; i++) mem[i] = $urandom;
            launch();
            cyc = 0; aborted = 1'b0;
            while (!done && !aborted && cyc < 300) begin
                stall = ($urandom_range(0, 3) == 0);
                ab = ($urandom_range(0, 59) == 0);
                abort = ab;
                tick();
                abort = 1'b0;
                aborted = ab;
                cyc++;
            end
            stall = 1'b0;
            if (aborted) check("rand_abort_idle", {busy, done}, 2'b00);
            else check("rand_done_seen", done, 1'b1);
            tick();
            tick();
        end

        // PROG_LEN=1 instance: one valid word, done after E3.
        p1_start = 1'b1;
        tick();
        p1_start = 1'b0;
        cyc = 0; vcnt = 0;
        while (!p1_done && cyc < 50) begin
            tick();
            cyc++;
            if (p1_valid) begin
                vcnt++;
                check("p1_word", {p1_pc, p1_instr}, {AW'(0), 32'h6800_0000});
            end
        end
        check("p1_done_latency", cyc, 3);
        check("p1_valid_count", vcnt, 1);
        tick();
        check("p1_idle", {p1_busy, p1_done}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
